dmem_port_arbiter: RTL and testbench

- Sits between the post-commit store buffer drain port, the load unit, and the single-ported data cache.
- Acts as the responder for the store buffer's write-drain protocol (req/busy/resp). Also accepts loads over a valid/ready handshake.
- Arbitrates both sources onto one dcache request with at most one access in flight. Loads have priority, bounded by a store-starvation counter.
- Supports load flush on mispredict. Committed stores are never flushed.

---
 rtl/dmem_arb_pkg.sv | 18 +
 rtl/dmem_port_arbiter.sv | 139 +++++++++++++
 tb/tb_dmem_port_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory port arbiter: FSM states and the
// registered store-drain slot.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STORE_WAIT,
    LOAD_WAIT
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic        valid;
  } store_slot_t;

endpackage

// File: rtl/dmem_port_arbiter.sv
// Merges committed store drains and loads onto one single-ported dcache
// request, one access in flight, loads first unless a store has starved.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_WIDTH    = $clog2(STARVE_LIMIT + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_req,
  input  logic [31:0] st_addr,
  input  logic [3:0]  st_wmask,
  input  logic [31:0] st_wdata,
  output logic        st_busy,
  output logic        st_resp,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_addr,
  input  logic [3:0]  ld_rmask,
  output logic        ld_resp,
  output logic [31:0] ld_rdata,
  input  logic        flush,
  output logic [31:0] dc_addr,
  output logic [3:0]  dc_rmask,
  output logic [3:0]  dc_wmask,
  output logic [31:0] dc_wdata,
  input  logic [31:0] dc_rdata,
  input  logic        dc_resp
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(STARVE_LIMIT);

  state_t                state, state_next;
  store_slot_t           slot;
  logic                  drop;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  store_win;
  logic                  load_issue;
  logic                  store_done;

  assign store_win  = (state == IDLE) && slot.valid && (!ld_valid || flush || cnt == CNT_MAX);
  assign load_issue = (state == IDLE) && !store_win && ld_valid && !flush;
  assign store_done = (state == STORE_WAIT) && dc_resp;
  assign st_busy    = slot.valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Zero-mask drains are acknowledged by accepting st_req but never occupy the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot <= '0;
    end else if (store_done) begin
      slot.valid <= 1'b0;
    end else if (st_req && !slot.valid && st_wmask != 4'b0000) begin
      slot.addr  <= st_addr;
      slot.wmask <= st_wmask;
      slot.wdata <= st_wdata;
      slot.valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (store_win) begin
      cnt <= '0;
    end else if (load_issue && slot.valid && cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  // A flushed in-flight load still owns the cache until its response returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop <= 1'b0;
    end else if (state == LOAD_WAIT) begin
      if (dc_resp) begin
        drop <= 1'b0;
      end else if (flush) begin
        drop <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    ld_ready   = 1'b0;
    st_resp    = 1'b0;
    ld_resp    = 1'b0;
    ld_rdata   = 32'h0;
    dc_addr    = 32'h0;
    dc_rmask   = 4'b0000;
    dc_wmask   = 4'b0000;
    dc_wdata   = 32'h0;
    case (state)
      IDLE: begin
        if (store_win) begin
          dc_addr    = slot.addr & 32'hFFFF_FFFC;
          dc_wmask   = slot.wmask;
          dc_wdata   = slot.wdata;
          state_next = STORE_WAIT;
        end else if (load_issue) begin
          ld_ready   = 1'b1;
          dc_addr    = ld_addr & 32'hFFFF_FFFC;
          dc_rmask   = ld_rmask;
          state_next = LOAD_WAIT;
        end
      end
      STORE_WAIT: begin
        if (dc_resp) begin
          st_resp    = 1'b1;
          state_next = IDLE;
        end
      end
      LOAD_WAIT: begin
        if (dc_resp) begin
          ld_resp    = !drop && !flush;
          ld_rdata   = (!drop && !flush) ? dc_rdata : 32'h0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  a_no_req_busy: assert property (@(posedge clk) disable iff (rst) st_req |-> !st_busy);
  a_ld_mask:     assert property (@(posedge clk) disable iff (rst) ld_valid |-> ld_rmask != 4'b0000);
  a_resp_wait:   assert property (@(posedge clk) disable iff (rst) dc_resp |-> state != IDLE);
  a_ld_stable:   assert property (@(posedge clk) disable iff (rst)
                   (ld_valid && !ld_ready) |=> (!ld_valid || ($stable(ld_addr) && $stable(ld_rmask))));

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed, self-checking bench for dmem_port_arbiter; the bench plays both
// the store buffer / load unit and a hand-driven dcache.
module tb_dmem_port_arbiter;
  import dmem_arb_pkg::*;

  logic        clk;
  logic        rst;
  logic        st_req;
  logic [31:0] st_addr;
  logic [3:0]  st_wmask;
  logic [31:0] st_wdata;
  logic        st_busy;
  logic        st_resp;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_addr;
  logic [3:0]  ld_rmask;
  logic        ld_resp;
  logic [31:0] ld_rdata;
  logic        flush;
  logic [31:0] dc_addr;
  logic [3:0]  dc_rmask;
  logic [3:0]  dc_wmask;
  logic [31:0] dc_wdata;
  logic [31:0] dc_rdata;
  logic        dc_resp;

  int checks;
  int errors;

  dmem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .st_req(st_req), .st_addr(st_addr), .st_wmask(st_wmask), .st_wdata(st_wdata),
    .st_busy(st_busy), .st_resp(st_resp),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_rmask(ld_rmask),
    .ld_resp(ld_resp), .ld_rdata(ld_rdata),
    .flush(flush),
    .dc_addr(dc_addr), .dc_rmask(dc_rmask), .dc_wmask(dc_wmask), .dc_wdata(dc_wdata),
    .dc_rdata(dc_rdata), .dc_resp(dc_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1-2 time units after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    checks++; if (dut.state !== IDLE) begin errors++; $display("[TB] FAIL reset_state: got %0d expected %0d", dut.state, IDLE); end
    checks++; if (st_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_st_busy: got %0b expected 0", st_busy); end
    checks++; if (st_resp !== 1'b0 || ld_resp !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp: got st=%0b ld=%0b expected 0/0", st_resp, ld_resp); end
    checks++; if (dc_rmask !== 4'h0 || dc_wmask !== 4'h0) begin errors++; $display("[TB] FAIL reset_masks: got r=%h w=%h expected 0/0", dc_rmask, dc_wmask); end
    checks++; if (dut.cnt !== 3'd0 || dut.drop !== 1'b0) begin errors++; $display("[TB] FAIL reset_cnt_drop: got cnt=%0d drop=%0b expected 0/0", dut.cnt, dut.drop); end
    checks++; if (ld_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_ld_rdata: got %h expected 0", ld_rdata); end
    step();
  endtask

  task automatic test_store_only();
    st_req = 1'b1; st_addr = 32'h1000_0006; st_wmask = 4'b1100; st_wdata = 32'hAABB_0000;
    #1;
    checks++; if (st_busy !== 1'b0) begin errors++; $display("[TB] FAIL store_busy_early: got %0b expected 0", st_busy); end
    step();
    st_req = 1'b0;
    #1;
    checks++; if (st_busy !== 1'b1) begin errors++; $display("[TB] FAIL store_busy: got %0b expected 1", st_busy); end
    checks++; if (dc_wmask !== 4'b1100 || dc_rmask !== 4'h0) begin errors++; $display("[TB] FAIL store_issue_mask: got w=%h r=%h expected c/0", dc_wmask, dc_rmask); end
    checks++; if (dc_addr !== 32'h1000_0004 || dc_wdata !== 32'hAABB_0000) begin errors++; $display("[TB] FAIL store_issue_addr: got %h/%h expected 10000004/aabb0000", dc_addr, dc_wdata); end
    step();
    checks++; if (dc_wmask !== 4'h0) begin errors++; $display("[TB] FAIL store_pulse: got %h expected 0", dc_wmask); end
    step();
    step();
    dc_resp = 1'b1;
    #1;
    checks++; if (st_resp !== 1'b1 || st_busy !== 1'b1) begin errors++; $display("[TB] FAIL store_resp: got resp=%0b busy=%0b expected 1/1", st_resp, st_busy); end
    step();
    dc_resp = 1'b0;
    #1;
    checks++; if (st_resp !== 1'b0 || st_busy !== 1'b0) begin errors++; $display("[TB] FAIL store_release: got resp=%0b busy=%0b expected 0/0", st_resp, st_busy); end
    checks++; if (dut.state !== IDLE) begin errors++; $display("[TB] FAIL store_idle: got %0d expected %0d", dut.state, IDLE); end
    step();
  endtask

  task automatic test_load_priority();
    st_req = 1'b1; st_addr = 32'h3000_0008; st_wmask = 4'hF; st_wdata = 32'h1234_5678;
    step();
    st_req = 1'b0;
    ld_valid = 1'b1; ld_addr = 32'h2000_0000; ld_rmask = 4'hF;
    #1;
    checks++; if (ld_ready !== 1'b1 || dc_rmask !== 4'hF || dc_wmask !== 4'h0) begin errors++; $display("[TB] FAIL prio_issue: got rdy=%0b r=%h w=%h expected 1/f/0", ld_ready, dc_rmask, dc_wmask); end
    checks++; if (dc_addr !== 32'h2000_0000) begin errors++; $display("[TB] FAIL prio_addr: got %h expected 20000000", dc_addr); end
    step();
    ld_valid = 1'b0;
    #1;
    checks++; if (dut.cnt !== 3'd1) begin errors++; $display("[TB] FAIL prio_cnt: got %0d expected 1", dut.cnt); end
    checks++; if (dc_rmask !== 4'h0 || ld_ready !== 1'b0 || st_busy !== 1'b1) begin errors++; $display("[TB] FAIL prio_wait: got r=%h rdy=%0b busy=%0b expected 0/0/1", dc_rmask, ld_ready, st_busy); end
    step();
    dc_resp = 1'b1; dc_rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (ld_resp !== 1'b1 || ld_rdata !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL prio_ld_resp: got %0b/%h expected 1/deadbeef", ld_resp, ld_rdata); end
    step();
    dc_resp = 1'b0;
    #1;
    checks++; if (ld_resp !== 1'b0 || ld_rdata !== 32'h0) begin errors++; $display("[TB] FAIL prio_rdata_zero: got %0b/%h expected 0/0", ld_resp, ld_rdata); end
    checks++; if (dc_wmask !== 4'hF || dc_addr !== 32'h3000_0008 || dc_wdata !== 32'h1234_5678) begin errors++; $display("[TB] FAIL prio_store_issue: got w=%h a=%h d=%h expected f/30000008/12345678", dc_wmask, dc_addr, dc_wdata); end
    step();
    checks++; if (dut.cnt !== 3'd0) begin errors++; $display("[TB] FAIL prio_cnt_clear: got %0d expected 0", dut.cnt); end
    dc_resp = 1'b1;
    #1;
    checks++; if (st_resp !== 1'b1) begin errors++; $display("[TB] FAIL prio_st_resp: got %0b expected 1", st_resp); end
    step();
    dc_resp = 1'b0;
    step();
  endtask

  task automatic test_starvation();
    st_req = 1'b1; st_addr = 32'h4000_0010; st_wmask = 4'b0011; st_wdata = 32'h55AA_55AA;
    step();
    st_req = 1'b0;
    ld_valid = 1'b1; ld_addr = 32'h5000_0000; ld_rmask = 4'hF;
    for (int k = 1; k <= 4; k++) begin
      #1;
      checks++; if (ld_ready !== 1'b1 || dc_rmask !== 4'hF || dc_wmask !== 4'h0) begin errors++; $display("[TB] FAIL starve_load%0d: got rdy=%0b r=%h w=%h expected 1/f/0", k, ld_ready, dc_rmask, dc_wmask); end
      step();
      checks++; if (dut.cnt !== 3'(k)) begin errors++; $display("[TB] FAIL starve_cnt%0d: got %0d expected %0d", k, dut.cnt, k); end
      dc_resp = 1'b1; dc_rdata = 32'(k) * 32'h0101_0101;
      #1;
      checks++; if (ld_resp !== 1'b1 || ld_rdata !== 32'(k) * 32'h0101_0101) begin errors++; $display("[TB] FAIL starve_resp%0d: got %0b/%h", k, ld_resp, ld_rdata); end
      step();
      dc_resp = 1'b0;
    end
    #1;
    checks++; if (ld_ready !== 1'b0 || dc_wmask !== 4'b0011 || dc_rmask !== 4'h0) begin errors++; $display("[TB] FAIL starve_store_win: got rdy=%0b w=%h r=%h expected 0/3/0", ld_ready, dc_wmask, dc_rmask); end
    checks++; if (dc_addr !== 32'h4000_0010 || dc_wdata !== 32'h55AA_55AA) begin errors++; $display("[TB] FAIL starve_store_addr: got %h/%h expected 40000010/55aa55aa", dc_addr, dc_wdata); end
    step();
    checks++; if (dut.cnt !== 3'd0 || ld_ready !== 1'b0) begin errors++; $display("[TB] FAIL starve_cnt_clear: got cnt=%0d rdy=%0b expected 0/0", dut.cnt, ld_ready); end
    dc_resp = 1'b1;
    step();
    dc_resp = 1'b0;
    #1;
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("[TB] FAIL starve_load_resume: got %0b expected 1", ld_ready); end
    step();
    ld_valid = 1'b0;
    dc_resp = 1'b1;
    step();
    dc_resp = 1'b0;
    step();
  endtask

  task automatic test_flush_inflight();
    ld_valid = 1'b1; ld_addr = 32'h6000_0004; ld_rmask = 4'b0110;
    #1;
    checks++; if (ld_ready !== 1'b1 || dc_rmask !== 4'b0110) begin errors++; $display("[TB] FAIL flush_issue: got rdy=%0b r=%h expected 1/6", ld_ready, dc_rmask); end
    step();
    ld_valid = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    checks++; if (dut.drop !== 1'b1 || dut.state !== LOAD_WAIT) begin errors++; $display("[TB] FAIL flush_drop: got drop=%0b st=%0d expected 1/%0d", dut.drop, dut.state, LOAD_WAIT); end
    step();
    dc_resp = 1'b1; dc_rdata = 32'hCAFE_F00D;
    #1;
    checks++; if (ld_resp !== 1'b0 || ld_rdata !== 32'h0) begin errors++; $display("[TB] FAIL flush_suppress: got %0b/%h expected 0/0", ld_resp, ld_rdata); end
    step();
    dc_resp = 1'b0;
    #1;
    checks++; if (dut.state !== IDLE || dut.drop !== 1'b0) begin errors++; $display("[TB] FAIL flush_return: got st=%0d drop=%0b expected %0d/0", dut.state, dut.drop, IDLE); end
    ld_valid = 1'b1; ld_addr = 32'h6000_0008; ld_rmask = 4'hF;
    #1;
    checks++; if (ld_ready !== 1'b1 || dc_addr !== 32'h6000_0008) begin errors++; $display("[TB] FAIL flush_next_load: got rdy=%0b a=%h expected 1/60000008", ld_ready, dc_addr); end
    step();
    ld_valid = 1'b0;
    dc_resp = 1'b1; dc_rdata = 32'h0BAD_CAFE;
    #1;
    checks++; if (ld_resp !== 1'b1 || ld_rdata !== 32'h0BAD_CAFE) begin errors++; $display("[TB] FAIL flush_next_resp: got %0b/%h expected 1/0badcafe", ld_resp, ld_rdata); end
    step();
    dc_resp = 1'b0;
    step();
  endtask

  task automatic test_flush_arbitration();
    flush = 1'b1; ld_valid = 1'b1; ld_addr = 32'h7000_0000; ld_rmask = 4'hF;
    #1;
    checks++; if (ld_ready !== 1'b0 || dc_rmask !== 4'h0 || dc_wmask !== 4'h0) begin errors++; $display("[TB] FAIL flusharb_block: got rdy=%0b r=%h w=%h expected 0/0/0", ld_ready, dc_rmask, dc_wmask); end
    step();
    checks++; if (dut.state !== IDLE) begin errors++; $display("[TB] FAIL flusharb_state: got %0d expected %0d", dut.state, IDLE); end
    flush = 1'b0; ld_valid = 1'b0;
    step();
  endtask

  task automatic test_zero_mask_and_reset();
    st_req = 1'b1; st_addr = 32'h8000_0000; st_wmask = 4'h0; st_wdata = 32'hFFFF_FFFF;
    step();
    st_req = 1'b0;
    #1;
    checks++; if (st_busy !== 1'b0 || dc_wmask !== 4'h0 || dut.state !== IDLE) begin errors++; $display("[TB] FAIL zmask_ignored: got busy=%0b w=%h st=%0d expected 0/0/%0d", st_busy, dc_wmask, dut.state, IDLE); end
    step();
    checks++; if (st_busy !== 1'b0 || st_resp !== 1'b0) begin errors++; $display("[TB] FAIL zmask_quiet: got busy=%0b resp=%0b expected 0/0", st_busy, st_resp); end
    st_req = 1'b1; st_addr = 32'h9000_0001; st_wmask = 4'b0001; st_wdata = 32'h0000_00FF;
    step();
    st_req = 1'b0;
    #1;
    checks++; if (dc_wmask !== 4'b0001 || dc_addr !== 32'h9000_0000) begin errors++; $display("[TB] FAIL zmask_real_store: got w=%h a=%h expected 1/90000000", dc_wmask, dc_addr); end
    step();
    rst = 1'b1;
    #1;
    checks++; if (dut.state !== STORE_WAIT) begin errors++; $display("[TB] FAIL rst_pre_state: got %0d expected %0d", dut.state, STORE_WAIT); end
    step();
    rst = 1'b0;
    #1;
    checks++; if (dut.state !== IDLE || st_busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_store: got st=%0d busy=%0b expected %0d/0", dut.state, st_busy, IDLE); end
    checks++; if (dc_rmask !== 4'h0 || dc_wmask !== 4'h0) begin errors++; $display("[TB] FAIL rst_masks: got r=%h w=%h expected 0/0", dc_rmask, dc_wmask); end
    step();
    checks++; if (dc_wmask !== 4'h0 || st_busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_no_reissue: got w=%h busy=%0b expected 0/0", dc_wmask, st_busy); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    st_req = 1'b0; st_addr = 32'h0; st_wmask = 4'h0; st_wdata = 32'h0;
    ld_valid = 1'b0; ld_addr = 32'h0; ld_rmask = 4'hF;
    flush = 1'b0; dc_rdata = 32'h0; dc_resp = 1'b0;
    test_reset();
    test_store_only();
    test_load_priority();
    test_starvation();
    test_flush_inflight();
    test_flush_arbitration();
    test_zero_mask_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
